// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned STRB_WIDTH = 8;

  typedef enum logic [1:0] {
    MemSizeB = 2'd0,
    MemSizeH = 2'd1,
    MemSizeW = 2'd2,
    MemSizeD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    MasIdle = 2'd0,
    MasReq  = 2'd1,
    MasDone = 2'd2
  } mas_state_e;

  // Natural alignment: the low address bits must be zero for the access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic ok;
    unique case (mem_size_e'(size))
      MemSizeB: ok = 1'b1;
      MemSizeH: ok = ~addr_lo[0];
      MemSizeW: ok = (addr_lo[1:0] == 2'b00);
      default:  ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [STRB_WIDTH-1:0] base_mask(input logic [1:0] size);
    logic [STRB_WIDTH-1:0] m;
    unique case (mem_size_e'(size))
      MemSizeB: m = 8'h01;
      MemSizeH: m = 8'h03;
      MemSizeW: m = 8'h0F;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: store strobes/data shifted up to their lanes,
// load data shifted down so the addressed byte lands in bit 0.
module mem_access_ctrl_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DW = 64
) (
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [2:0]        rd_off_i,
  input  logic [DW-1:0]     rdata_i,
  output logic [DW/8-1:0]   strb_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW-1:0]     rdata_o
);

  logic [DW/8-1:0] w_base;
  logic [5:0]      w_wshift;
  logic [5:0]      w_rshift;

  always_comb begin
    w_base   = (DW/8)'(base_mask(size_i));
    w_wshift = {addr_lo_i, 3'b000};
    w_rshift = {rd_off_i, 3'b000};
    strb_o   = we_i ? (w_base << addr_lo_i) : '0;
    wdata_o  = wdata_i << w_wshift;
    rdata_o  = rdata_i >> w_rshift;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer onto the data-memory req/ack bus with pipeline stall.
// Optional bus timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DW          = 64,
  parameter int unsigned AW          = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [1:0]        size_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [AW-1:0]     bus_addr_o,
  output logic [DW-1:0]     bus_wdata_o,
  output logic [DW/8-1:0]   bus_strb_o,
  input  logic              bus_ack_i,
  input  logic [DW-1:0]     bus_rdata_i,
  output logic              hold_n_o,
  output logic [DW-1:0]     data_mem_o,
  output logic              misalign_o,
  output logic              err_o
);

  mas_state_e r_state, w_state_nxt;

  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_strb;
  logic [2:0]      r_off;
  logic [DW-1:0]   r_data_mem;
  logic            r_misalign;

  logic            w_aligned;
  logic            w_start;
  logic            w_misal;
  logic            w_ack;
  logic            w_timeout;
  logic [DW/8-1:0] w_strb;
  logic [DW-1:0]   w_wdata_sh;
  logic [DW-1:0]   w_rdata_sh;

  assign w_aligned = is_aligned(size_i, addr_i[2:0]);
  assign w_start   = (r_state == MasIdle) && mem_en_i && w_aligned;
  assign w_misal   = (r_state == MasIdle) && mem_en_i && !w_aligned;
  assign w_ack     = (r_state == MasReq) && bus_ack_i;

  mem_access_ctrl_lane_align #(
    .DW (DW)
  ) u_lane_align (
    .we_i      (mem_we_i),
    .size_i    (size_i),
    .addr_lo_i (addr_i[2:0]),
    .wdata_i   (wdata_i),
    .rd_off_i  (r_off),
    .rdata_i   (bus_rdata_i),
    .strb_o    (w_strb),
    .wdata_o   (w_wdata_sh),
    .rdata_o   (w_rdata_sh)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_err;

  // An ack on the terminal cycle completes normally instead of aborting.
  assign w_timeout = (r_state == MasReq) && !bus_ack_i && (r_to_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_start) begin
        r_to_cnt <= '0;
      end else if ((r_state == MasReq) && !bus_ack_i) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
  assign err_o            = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MasIdle: if (w_start) w_state_nxt = MasReq;
      MasReq:  if (bus_ack_i || w_timeout) w_state_nxt = MasDone;
      MasDone: w_state_nxt = MasIdle;
      default: w_state_nxt = MasIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MasIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_off      <= '0;
      r_data_mem <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misal;
      if (w_start) begin
        r_we    <= mem_we_i;
        r_addr  <= {addr_i[AW-1:3], 3'b000};
        r_wdata <= w_wdata_sh;
        r_strb  <= w_strb;
        r_off   <= addr_i[2:0];
      end
      if (w_ack && !r_we) begin
        r_data_mem <= w_rdata_sh;
      end else if (w_timeout) begin
        r_data_mem <= '0;
      end
    end
  end

  // Stall from the cycle a valid access is seen until the ack has been taken.
  assign hold_n_o    = !(w_start || (r_state == MasReq));
  assign bus_req_o   = (r_state == MasReq);
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign bus_strb_o  = r_strb;
  assign data_mem_o  = r_data_mem;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboard of expected bus fields and load data.
module tb_mem_access_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;

  logic            clk;
  logic            rst_n;
  logic            mem_en_i;
  logic            mem_we_i;
  logic [1:0]      size_i;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   wdata_i;
  logic            bus_req_o;
  logic            bus_we_o;
  logic [AW-1:0]   bus_addr_o;
  logic [DW-1:0]   bus_wdata_o;
  logic [DW/8-1:0] bus_strb_o;
  logic            bus_ack_i;
  logic [DW-1:0]   bus_rdata_i;
  logic            hold_n_o;
  logic [DW-1:0]   data_mem_o;
  logic            misalign_o;
  logic            err_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_data_mem;

  mem_access_ctrl #(
    .DW          (DW),
    .AW          (AW),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_en_i    (mem_en_i),
    .mem_we_i    (mem_we_i),
    .size_i      (size_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_strb_o  (bus_strb_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .hold_n_o    (hold_n_o),
    .data_mem_o  (data_mem_o),
    .misalign_o  (misalign_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_strb(input logic we, input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] s;
    int nb;
    s  = '0;
    nb = 1 << sz;
    if (we) for (int i = 0; i < 8; i++) if (i >= int'(off) && i < int'(off) + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] w, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i >= int'(off)) r[8*i +: 8] = w[8*(i-int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] d, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i + int'(off) < 8) r[8*i +: 8] = d[8*(i+int'(off)) +: 8];
    return r;
  endfunction

  // Starts in an IDLE cycle; returns one cycle after DONE, back in IDLE.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int req_cycles, input string name);
    exp_t e;
    int   hold_low;
    e.addr  = {addr[63:3], 3'b000};
    e.we    = we;
    e.strb  = m_strb(we, sz, addr[2:0]);
    e.wdata = m_wdata(wdata, addr[2:0]);
    e.data  = we ? exp_data_mem : m_rdata(rdata, addr[2:0]);
    exp_data_mem = e.data;
    exp_q.push_back(e);
    mem_en_i = 1'b1; mem_we_i = we; size_i = sz; addr_i = addr; wdata_i = wdata;
    #1;
    hold_low = (hold_n_o === 1'b0) ? 1 : 0;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus_addr_o !== e.addr) begin
      $display("FAIL %s bus_addr got=%h exp=%h", name, bus_addr_o, e.addr); n_errors++;
    end
    n_checks++;
    if (bus_we_o !== e.we) begin
      $display("FAIL %s bus_we got=%b exp=%b", name, bus_we_o, e.we); n_errors++;
    end
    n_checks++;
    if (bus_strb_o !== e.strb) begin
      $display("FAIL %s bus_strb got=%h exp=%h", name, bus_strb_o, e.strb); n_errors++;
    end
    if (we) begin
      n_checks++;
      if (bus_wdata_o !== e.wdata) begin
        $display("FAIL %s bus_wdata got=%h exp=%h", name, bus_wdata_o, e.wdata); n_errors++;
      end
    end
    for (int c = 0; c < req_cycles; c++) begin
      if (hold_n_o === 1'b0) hold_low++;
      n_checks++;
      if (bus_req_o !== 1'b1) begin
        $display("FAIL %s bus_req cycle %0d got=%b exp=1", name, c, bus_req_o); n_errors++;
      end
      if (c == req_cycles - 1) begin
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
      end
      tick();
      bus_ack_i = 1'b0; bus_rdata_i = {$urandom, $urandom};
    end
    n_checks++;
    if (bus_req_o !== 1'b0 || hold_n_o !== 1'b1) begin
      $display("FAIL %s done req/hold_n got=%b/%b exp=0/1", name, bus_req_o, hold_n_o);
      n_errors++;
    end
    n_checks++;
    if (data_mem_o !== e.data) begin
      $display("FAIL %s data_mem got=%h exp=%h", name, data_mem_o, e.data); n_errors++;
    end
    n_checks++;
    if (hold_low !== req_cycles + 1) begin
      $display("FAIL %s hold_low_cycles got=%0d exp=%0d", name, hold_low, req_cycles + 1);
      n_errors++;
    end
    n_checks++;
    if (err_o !== 1'b0 || misalign_o !== 1'b0) begin
      $display("FAIL %s err/misalign got=%b/%b exp=0/0", name, err_o, misalign_o); n_errors++;
    end
    mem_en_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_en_i = 1'b0; mem_we_i = 1'b0; size_i = '0; addr_i = '0; wdata_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0; exp_data_mem = '0;
    #2;
    n_checks++;
    if ({bus_req_o, bus_we_o, misalign_o, err_o, hold_n_o} !== 5'b00001) begin
      $display("FAIL reset ctrl got=%b exp=00001",
               {bus_req_o, bus_we_o, misalign_o, err_o, hold_n_o});
      n_errors++;
    end
    n_checks++;
    if (bus_addr_o !== '0 || bus_wdata_o !== '0 || bus_strb_o !== '0 || data_mem_o !== '0) begin
      $display("FAIL reset data got=%h/%h/%h/%h exp=0", bus_addr_o, bus_wdata_o, bus_strb_o,
               data_mem_o);
      n_errors++;
    end
    tick();
    rst_n = 1'b1;
    // Stray ack while idle must not load data.
    bus_ack_i = 1'b1; bus_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    bus_ack_i = 1'b0;
    n_checks++;
    if (data_mem_o !== '0 || bus_req_o !== 1'b0) begin
      $display("FAIL idle_ack data_mem/req got=%h/%b exp=0/0", data_mem_o, bus_req_o);
      n_errors++;
    end
  endtask

  task automatic test_load();
    do_access(1'b0, 2'd2, 64'h1004, 64'h0, 64'hAABBCCDD_11223344, 2, "load_word");
    do_access(1'b0, 2'd0, 64'h1007, 64'h0, 64'h8877665544332211, 1, "load_byte");
    do_access(1'b0, 2'd1, 64'h100A, 64'h0, 64'h0123456789ABCDEF, 3, "load_half");
  endtask

  task automatic test_store();
    do_access(1'b1, 2'd0, 64'h2003, 64'h5A, 64'h0, 1, "store_byte");
    do_access(1'b1, 2'd1, 64'h2006, 64'hBEEF, 64'h0, 2, "store_half");
    do_access(1'b1, 2'd2, 64'h2004, 64'hCAFEF00D, 64'h0, 1, "store_word");
    do_access(1'b1, 2'd3, 64'h2008, 64'h1122334455667788, 64'h0, 1, "store_double");
  endtask

  task automatic test_misalign();
    mem_en_i = 1'b1; mem_we_i = 1'b0; size_i = 2'd1; addr_i = 64'h3001;
    #1;
    n_checks++;
    if (hold_n_o !== 1'b1 || bus_req_o !== 1'b0) begin
      $display("FAIL misalign hold_n/req got=%b/%b exp=1/0", hold_n_o, bus_req_o); n_errors++;
    end
    tick();
    mem_en_i = 1'b0;
    #1;
    n_checks++;
    if (misalign_o !== 1'b1 || bus_req_o !== 1'b0) begin
      $display("FAIL misalign pulse/req got=%b/%b exp=1/0", misalign_o, bus_req_o); n_errors++;
    end
    tick();
    n_checks++;
    if (misalign_o !== 1'b0 || bus_req_o !== 1'b0 || data_mem_o !== exp_data_mem) begin
      $display("FAIL misalign after pulse/req/data got=%b/%b/%h exp=0/0/%h", misalign_o,
               bus_req_o, data_mem_o, exp_data_mem);
      n_errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 2'd3, 64'h4000, 64'h0, 64'h0F0E0D0C0B0A0908, 1, "b2b_first");
    do_access(1'b0, 2'd3, 64'h4008, 64'h0, 64'hF1F2F3F4F5F6F7F8, 1, "b2b_second");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_access(1'b0, 2'd3, 64'h6000, 64'h0, 64'h5555AAAA5555AAAA, 255, "ack_terminal");
    mem_en_i = 1'b1; mem_we_i = 1'b0; size_i = 2'd3; addr_i = 64'h6008;
    tick();
    n = 0;
    while (bus_req_o === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 255) begin
      $display("FAIL timeout req_cycles got=%0d exp=255", n); n_errors++;
    end
    n_checks++;
    if (err_o !== 1'b1 || data_mem_o !== '0 || hold_n_o !== 1'b1) begin
      $display("FAIL timeout err/data/hold_n got=%b/%h/%b exp=1/0/1", err_o, data_mem_o,
               hold_n_o);
      n_errors++;
    end
    exp_data_mem = '0;
    mem_en_i = 1'b0;
    tick();
    n_checks++;
    if (err_o !== 1'b0) begin
      $display("FAIL timeout err_pulse_len got=%b exp=0", err_o); n_errors++;
    end
  endtask
`else
  task automatic test_timeout();
    do_access(1'b0, 2'd3, 64'h6000, 64'h0, 64'h5555AAAA5555AAAA, 300, "long_wait");
  endtask
`endif

  task automatic test_reset_mid();
    mem_en_i = 1'b1; mem_we_i = 1'b1; size_i = 2'd3; addr_i = 64'h5008;
    wdata_i = 64'h0102030405060708;
    tick();
    n_checks++;
    if (bus_req_o !== 1'b1) begin
      $display("FAIL rst_mid pre req got=%b exp=1", bus_req_o); n_errors++;
    end
    #2;
    rst_n = 1'b0; mem_en_i = 1'b0;
    #1;
    n_checks++;
    if ({bus_req_o, bus_we_o, misalign_o, err_o, hold_n_o} !== 5'b00001) begin
      $display("FAIL rst_mid ctrl got=%b exp=00001",
               {bus_req_o, bus_we_o, misalign_o, err_o, hold_n_o});
      n_errors++;
    end
    n_checks++;
    if (bus_addr_o !== '0 || bus_wdata_o !== '0 || bus_strb_o !== '0 || data_mem_o !== '0) begin
      $display("FAIL rst_mid data got=%h/%h/%h/%h exp=0", bus_addr_o, bus_wdata_o, bus_strb_o,
               data_mem_o);
      n_errors++;
    end
    tick();
    rst_n = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 64'h7777_6666_5555_4444;
    tick();
    bus_ack_i = 1'b0;
    tick();
    n_checks++;
    if (bus_req_o !== 1'b0 || data_mem_o !== '0 || hold_n_o !== 1'b1) begin
      $display("FAIL rst_mid late_ack req/data/hold_n got=%b/%h/%b exp=0/0/1", bus_req_o,
               data_mem_o, hold_n_o);
      n_errors++;
    end
    exp_data_mem = '0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
